// File: rtl/if_seq.sv
// Instruction fetch sequencer: gathers WORDS memory words per instruction
// and publishes the assembled instruction with a one-cycle valid pulse.
module if_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       pc_in,
    input  logic                    mfc,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_en,
    output logic                    mem_rw,
    output logic [WORDS*DATA_W-1:0] ir_out,
    output logic                    ir_valid,
    output logic [ADDR_W-1:0]       pc_next,
    output logic                    busy,
    output logic                    fault
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REQ,
        S_CAPT,
        S_LOAD,
        S_DONE,
        S_FAULT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0]            base;
    logic [IDX_W-1:0]             idx;
    logic [7:0]                   tcnt;
    logic [WORDS-1:0][DATA_W-1:0] wbuf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state_nx = S_ADDR;
                S_ADDR:  state_nx = S_REQ;
                S_REQ: begin
                    // a late mfc on the last allowed cycle still wins
                    if (mfc)                 state_nx = S_CAPT;
                    else if (tcnt == T_LAST) state_nx = S_FAULT;
                end
                S_CAPT:  state_nx = (idx == IDX_LAST) ? S_LOAD : S_ADDR;
                S_LOAD:  state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                S_FAULT: state_nx = S_FAULT;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_rw   = 1'b0;
        ir_valid = 1'b0;
        busy     = 1'b0;
        fault    = 1'b0;
        mem_en   = (state == S_REQ);
        mem_rw   = (state != S_IDLE);
        ir_valid = (state == S_DONE);
        busy     = (state != S_IDLE) && (state != S_FAULT);
        fault    = (state == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            idx      <= '0;
            tcnt     <= '0;
            wbuf     <= '0;
            mem_addr <= '0;
            ir_out   <= '0;
            pc_next  <= '0;
        end else if (!flush) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base <= pc_in;
                        idx  <= '0;
                    end
                end
                S_ADDR: begin
                    mem_addr <= base + ADDR_W'(idx);
                    tcnt     <= '0;
                end
                S_REQ: begin
                    if (mfc) wbuf[idx] <= mem_rdata;
                    else     tcnt      <= tcnt + 8'd1;
                end
                S_CAPT: begin
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                end
                // the only place ir_out moves, so partial fetches stay hidden
                S_LOAD: begin
                    ir_out  <= wbuf;
                    pc_next <= base + ADDR_W'(WORDS);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_seq.sv
// Scoreboard bench for if_seq: random memory latency, directed
// wrap, timeout, flush and asynchronous reset scenarios.
module tb_if_seq;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [7:0]  pc_in;
    logic        mfc = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [7:0]  mem_addr;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [7:0]  pc_next;
    logic        busy;
    logic        fault;

    if_seq #(
        .ADDR_W(8), .DATA_W(16), .WORDS(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .pc_in(pc_in), .mfc(mfc), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rw(mem_rw),
        .ir_out(ir_out), .ir_valid(ir_valid), .pc_next(pc_next),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [7:0]  pcn;
    } exp_t;

    exp_t        ir_q[$];
    logic [7:0]  addr_q[$];
    logic [15:0] mem[256];
    logic [31:0] last_ir = 32'h0;

    int n_chk = 0;
    int n_pass = 0;

    int force_delay = -1;
    bit no_mfc = 1'b0;
    bit noise = 1'b0;
    int c = 0;
    int d = 0;
    int last_len = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // memory responder: mfc after d extra REQ cycles, optional noise outside REQ
    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            if (c == 0) begin
                d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                if (addr_q.size() == 0) chk("mem_en_unexpected", mem_en, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            mfc = !no_mfc && (c == d);
            mem_rdata = mem[mem_addr];
            c++;
        end else begin
            if (c != 0) last_len = c;
            c = 0;
            mfc = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    // monitor: pops expected instruction on ir_valid, else ir_out must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (ir_valid) begin
                if (ir_q.size() == 0) begin
                    chk("ir_valid_unexpected", ir_valid, 0);
                end else begin
                    exp_t e;
                    e = ir_q.pop_front();
                    chk("ir_out", ir_out, e.ir);
                    chk("pc_next", pc_next, e.pcn);
                    last_ir = e.ir;
                end
            end else begin
                chk("ir_out_hold", ir_out, last_ir);
            end
        end
    end

    task automatic issue(input logic [7:0] pc, input bit want_ir,
                         input int nwords);
        logic [7:0] a1;
        exp_t e;
        a1 = pc + 8'd1;
        e.ir = {mem[a1], mem[pc]};
        e.pcn = pc + 8'd2;
        addr_q.push_back(pc);
        if (nwords > 1) addr_q.push_back(a1);
        if (want_ir) ir_q.push_back(e);
        pc_in = pc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_rw"}, mem_rw, 0);
        chk({tag, "_ir_out"}, ir_out, 0);
        chk({tag, "_ir_valid"}, ir_valid, 0);
        chk({tag, "_pc_next"}, pc_next, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h10] = 16'hAAAA;
        mem[8'h11] = 16'h5555;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        pc_in = 8'h0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic two-word fetch
        force_delay = 1;
        issue(8'h10, 1, 2);
        wait_idle("done_basic");
        chk("ir_basic", ir_out, 32'h5555AAAA);
        chk("pcn_basic", pc_next, 8'h12);

        // address wrap
        force_delay = -1;
        noise = 1'b1;
        issue(8'hFF, 1, 2);
        wait_idle("done_wrap");
        chk("pcn_wrap", pc_next, 8'h01);

        // timeout into FAULT, start ignored, flush recovers
        no_mfc = 1'b1;
        p = 8'($urandom);
        issue(p, 0, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fault) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fault_rise", ok, 1);
        @(negedge clk);
        chk("fault_mem_en", mem_en, 0);
        chk("fault_req_len", last_len, TO);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("fault_hold", fault, 1);
        chk("fault_busy", busy, 0);
        chk("fault_mem_en2", mem_en, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_fault_clr", fault, 0);
        chk("flush_fault_busy", busy, 0);
        no_mfc = 1'b0;

        // mfc on the last allowed REQ cycle
        force_delay = TO - 1;
        issue(8'($urandom), 1, 2);
        wait_idle("done_edge");
        chk("edge_no_fault", fault, 0);

        // flush during second-word REQ
        force_delay = 8;
        p = 8'($urandom);
        issue(p, 0, 2);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 8'(p + 8'd1)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("flush_reach_w1", ok, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_mem_en", mem_en, 0);
        chk("flush_ir_keep", ir_out, last_ir);
        repeat (4) @(negedge clk);

        // asynchronous reset mid-REQ
        force_delay = 3;
        issue(8'($urandom), 1, 2);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_reach_req", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        ir_q.delete();
        addr_q.delete();
        last_ir = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // randomized traffic
        force_delay = -1;
        for (int n = 0; n < 30; n++) begin
            issue(8'($urandom), 1, 2);
            wait_idle("done_rand");
        end
        repeat (4) @(negedge clk);
        chk("ir_q_empty", ir_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
